// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and PC sequencing ahead of the decode controller.
// Fetches one 32-bit word per instruction over a req/ack handshake, holds it in
// the instruction register, then picks the next PC from the controller's
// Jump/Branch decisions. A per-fetch wait counter retries stuck requests.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        Jump,
    input  logic        Branch,
    input  logic [31:0] jr_target,
    input  logic        stall,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

    // Word-aligned reset address.
    localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;
    // Counter value on the last cycle allowed to wait for an ack.
    localparam logic [3:0]  WAIT_LAST = 4'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  wait_q, wait_d;
    logic        gap_q, gap_d;      // one-cycle request drop after a timeout
    logic        err_q, err_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    assign pc_plus4_w = pc_q + 32'd4;
    assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    // Next-PC selection: jr, then j/jal, then taken branch, then sequential.
    always_comb begin
        next_pc = pc_plus4_w;
        if (Jump && (ir_q[31:26] == 6'd0)) begin
            next_pc = {jr_target[31:2], 2'b00};
        end else if (Jump) begin
            next_pc = {pc_plus4_w[31:28], ir_q[25:0], 2'b00};
        end else if (Branch) begin
            next_pc = pc_plus4_w + branch_off;
        end
    end

    // FSM next-state and datapath updates; everything holds by default.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            S_FETCH: begin
                if (gap_q) begin
                    // Request is low this cycle; any ack is ignored.
                    gap_d = 1'b0;
                end else if (imem_ack) begin
                    // An ack on the would-be timeout cycle still wins.
                    ir_d    = imem_rdata;
                    wait_d  = 4'd0;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d  = 1'b1;
                    wait_d = 4'd0;
                    gap_d  = 1'b1;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    count_d = count_q + 32'd1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= PC_INIT;
            ir_q    <= 32'd0;
            wait_q  <= 4'd0;
            gap_q   <= 1'b0;
            err_q   <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH) && !gap_q && !rst;
    assign imem_addr   = pc_q;
    assign op          = ir_q[31:26];
    assign func        = ir_q[5:0];
    assign instr       = ir_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign instr_valid = (state_q != S_FETCH);
    assign fetch_err   = err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic, all checked every
// cycle against an instruction-level reference model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          TO  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        Jump = 1'b0;
    logic        Branch = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        stall = 1'b0;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_err;
    logic [31:0] instr_count;

    fetch_unit #(.RESET_PC(RPC), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Jump(Jump), .Branch(Branch), .jr_target(jr_target), .stall(stall),
        .op(op), .func(func), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .fetch_err(fetch_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    logic req_seen;

    // Reference model: where we are in the instruction (0 fetch, 1 decode,
    // 2 exec), how long the current request has waited, plus architectural state.
    int          m_phase;
    int          m_waited;
    bit          m_retry_gap;
    logic [31:0] m_pc, m_ir, m_cnt;
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] model_target();
        logic [31:0] seq;
        int off;
        seq = m_pc + 32'd4;
        if (Jump && m_ir[31:26] == 6'd0) return jr_target & 32'hFFFF_FFFC;
        if (Jump) return (seq & 32'hF000_0000) | ({6'd0, m_ir[25:0]} << 2);
        if (Branch) begin
            off = int'($signed(m_ir[15:0]));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    // Advance the model by one clock using the inputs just applied.
    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_waited = 0; m_retry_gap = 0;
            m_pc = RPC & 32'hFFFF_FFFC; m_ir = 32'd0; m_cnt = 32'd0; m_err = 0;
        end else if (m_phase == 0) begin
            if (m_retry_gap) begin
                m_retry_gap = 0;
            end else if (imem_ack) begin
                m_ir = imem_rdata; m_waited = 0; m_phase = 1;
            end else begin
                m_waited++;
                if (m_waited == TO) begin
                    m_err = 1; m_waited = 0; m_retry_gap = 1;
                end
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (!stall) begin
            m_pc  = model_target();
            m_cnt = m_cnt + 32'd1;
            m_phase = 0;
        end
    endtask

    // Apply one cycle of inputs at the falling edge; note the request level.
    task automatic drive(input logic a, input logic [31:0] rd, input logic j, input logic b,
                         input logic st, input logic [31:0] jt, input logic r);
        @(negedge clk);
        rst = r; imem_ack = a; imem_rdata = rd; Jump = j; Branch = b;
        stall = st; jr_target = jt;
        model_step();
        #1 req_seen = imem_req;
    endtask

    // Compare every DUT output against the model shortly after each edge.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("imem_req", 32'(imem_req), 32'(m_phase == 0 && !m_retry_gap && !rst));
            chk("imem_addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("instr", instr, m_ir);
            chk("op", 32'(op), 32'(m_ir[31:26]));
            chk("func", 32'(func), 32'(m_ir[5:0]));
            chk("instr_valid", 32'(instr_valid), 32'(m_phase != 0));
            chk("fetch_err", 32'(fetch_err), 32'(m_err));
            chk("instr_count", instr_count, m_cnt);
        end
    end

    // One complete instruction: fetch with 'waits' ack-less cycles, decode,
    // 'stalls' stalled exec cycles, then the deciding exec cycle.
    task automatic run_instr(input logic [31:0] ir, input logic j, input logic b,
                             input logic [31:0] jt, input int waits, input int stalls,
                             output int ncyc);
        int w;
        w = 0; ncyc = 0;
        while (m_phase == 0 && ncyc < 64) begin
            drive(w >= waits, ir, rbit(), rbit(), rbit(), $urandom, 1'b0);
            w++; ncyc++;
        end
        drive(rbit(), $urandom, rbit(), rbit(), rbit(), $urandom, 1'b0);
        ncyc++;
        for (int s = 0; s < stalls; s++) begin
            drive(rbit(), $urandom, rbit(), rbit(), 1'b1, $urandom, 1'b0);
            ncyc++;
        end
        drive(rbit(), $urandom, j, b, 1'b0, jt, 1'b0);
        ncyc++;
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0000;
            1: return {6'h04, 10'($urandom), 16'($urandom)};
            2: return {6'h02, 26'($urandom)};
            3: return 32'h03E0_0008;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nc;
        logic [9:0] pat;
        int hold;

        // Reset values.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'd0, 1'b1);
        chk_en = 1'b1;
        settle();
        chk("rst_req", 32'(req_seen), 32'd0);
        chk("rst_pc", pc, 32'h0000_0100);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", instr_count, 32'd0);

        // Sequential nops, zero-wait memory.
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", imem_addr, 32'h100 + 32'(i * 4));
            run_instr(32'h0, 1'b0, 1'b0, 32'd0, 0, 0, nc);
            chk("seq_period", 32'(nc), 32'd3);
            settle();
        end
        chk("seq_count", instr_count, 32'd3);
        chk("seq_pc", pc, 32'h0000_010C);

        // j to 0x200, then taken beq with offset -2.
        run_instr(32'h0800_0080, 1'b1, 1'b0, 32'd0, 1, 0, nc); settle();
        chk("j_200", pc, 32'h0000_0200);
        run_instr(32'h1000_FFFE, 1'b0, 1'b1, 32'd0, 0, 0, nc); settle();
        chk("beq_back", pc, 32'h0000_01FC);

        // jr into the 0x3 region, j within it, jr with unaligned target.
        run_instr(32'h03E0_0008, 1'b1, 1'b0, 32'h3000_0010, 2, 0, nc); settle();
        chk("jr_hi", pc, 32'h3000_0010);
        run_instr(32'h0800_0040, 1'b1, 1'b0, 32'd0, 0, 0, nc); settle();
        chk("j_region", pc, 32'h3000_0100);
        run_instr(32'h03E0_0008, 1'b1, 1'b0, 32'h0000_0ABF, 0, 0, nc); settle();
        chk("jr_align", pc, 32'h0000_0ABC);

        // Stall at the top of memory, then wrap to zero.
        run_instr(32'h03E0_0008, 1'b1, 1'b0, 32'hFFFF_FFFF, 0, 0, nc); settle();
        chk("jr_top", pc, 32'hFFFF_FFFC);
        run_instr(32'h0, 1'b0, 1'b0, 32'd0, 0, 5, nc); settle();
        chk("wrap_pc", pc, 32'h0000_0000);
        chk("wrap_count", instr_count, 32'd10);

        // Jump and Branch together: the jump wins.
        run_instr(32'h0800_0001, 1'b1, 1'b1, 32'd0, 0, 0, nc); settle();
        chk("jump_wins", pc, 32'h0000_0004);

        // Timeout and retry with the ack withheld.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        settle();
        chk("to_err_before", 32'(fetch_err), 32'd0);
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            pat[9 - i] = req_seen;
            chk("to_addr", imem_addr, 32'h0000_0100);
        end
        chk("to_req_pattern", 32'(pat), 32'(10'b1111011110));
        run_instr(32'h0, 1'b0, 1'b0, 32'd0, 0, 0, nc); settle();
        chk("to_recover_pc", pc, 32'h0000_0104);
        chk("to_err_sticky", 32'(fetch_err), 32'd1);

        // Reset in the middle of a waiting fetch, with an ack alongside it.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1);
        chk("mid_rst_req", 32'(req_seen), 32'd0);
        settle();
        chk("mid_rst_instr", instr, 32'd0);
        chk("mid_rst_pc", pc, 32'h0000_0100);
        chk("mid_rst_err", 32'(fetch_err), 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("mid_rst_rereq", 32'(req_seen), 32'd1);

        // Randomized traffic: bursty acks, random controller decisions, rare resets.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            logic a;
            if (hold > 0) begin
                a = 1'b0;
                hold--;
            end else begin
                a = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 30) == 0) hold = $urandom_range(3, 12);
            end
            drive(a, rand_instr(), rbit(), rbit(), ($urandom_range(0, 3) == 0),
                  $urandom, ($urandom_range(0, 149) == 0));
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
